exec_sequencer: RTL and testbench

- Control FSM for the matrix execution engine.
- Fetches 32-bit op words from op memory, decodes them, and reads up to two 256-bit operands from main memory or the register store.
- Dispatches operands to the selected functional unit (add/sub, multiply/scale, transpose) over the shared module bus, then writes the result back.
- Sits between op memory, mem/reg stores and the functional units. Replaces ad-hoc event-driven sequencing with a single clocked FSM.

---
 rtl/exec_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_exec_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_sequencer.sv
// Control sequencer for the matrix execution engine: fetch, decode, operand read, dispatch, writeback.
// Latency: each bus handshake costs one EN-high cycle plus the responder's delay; one gap cycle follows each handshake.
// Backpressure: every request holds its EN until the matching Fleg is sampled; a missing Fleg stalls indefinitely.
module exec_sequencer #(
   parameter int OP_AW  = 4,
   parameter int MEM_AW = 8,
   parameter int EW     = 16,
   parameter int DW     = 16 * EW
) (
   input  logic              clk,
   input  logic              RESET,
   input  logic              start,
   output logic [OP_AW-1:0]  opCounter,
   output logic              opEN,
   input  logic              opFleg,
   input  logic [31:0]       fromOpBus,
   output logic              memEN,
   output logic              memRW,
   output logic [MEM_AW-1:0] memAddr,
   input  logic              memFleg,
   input  logic [DW-1:0]     fromMemBus,
   output logic [DW-1:0]     toMemBus,
   output logic              regEN,
   output logic              regRW,
   input  logic              regFleg,
   input  logic [DW-1:0]     fromRegBus,
   output logic [DW-1:0]     toRegBus,
   output logic [1:0]        fuSel,
   output logic              add1sub0,
   output logic              fuEN,
   input  logic              fuFleg,
   output logic [DW-1:0]     toModuleBus,
   input  logic [DW-1:0]     fromModBus,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_RDA, S_RDB, S_DISPA, S_DISPB, S_WAITR,
      S_WB_MEM, S_WB_REG, S_WB_NONE, S_DONE, S_ERR
   } state_t;

   localparam logic [3:0] OPC_STOP = 4'd0;
   localparam logic [3:0] OPC_SUM  = 4'd1;
   localparam logic [3:0] OPC_SUB  = 4'd2;
   localparam logic [3:0] OPC_MUL  = 4'd3;
   localparam logic [3:0] OPC_SCA  = 4'd4;
   localparam logic [3:0] OPC_TRA  = 4'd5;

   localparam logic [1:0] DST_MEM  = 2'b00;
   localparam logic [1:0] DST_REG  = 2'b01;
   localparam logic [1:0] DST_BOTH = 2'b10;

   state_t          state;
   state_t          next_state;
   logic            hs_done;   // high for the cycle right after a completed handshake: forces EN low
   logic            ack;
   logic            start_ok;
   logic            leave_wb;
   logic [31:0]     op_word;
   logic [DW-1:0]   mat_a;
   logic [DW-1:0]   mat_b;
   logic [DW-1:0]   res;
   logic [DW-1:0]   sca_mat;

   // op word fields
   logic [3:0]      opcode;
   logic [1:0]      dest;
   logic [7:0]      dest_addr;
   logic            src1_reg;
   logic [7:0]      addr1;
   logic            src2_reg;
   logic [7:0]      addr2;

   assign opcode    = op_word[31:28];
   assign dest      = op_word[27:26];
   assign dest_addr = op_word[25:18];
   assign src1_reg  = op_word[17];
   assign addr1     = op_word[16:9];
   assign src2_reg  = op_word[8];
   assign addr2     = op_word[7:0];

   // Only one EN is ever active, so any EN/Fleg pair completes the current handshake.
   assign ack      = (opEN & opFleg) | (memEN & memFleg) | (regEN & regFleg) | (fuEN & fuFleg);
   assign start_ok = start && (state inside {S_IDLE, S_DONE, S_ERR});
   assign leave_wb = (state inside {S_WB_MEM, S_WB_REG, S_WB_NONE}) && (next_state == S_FETCH);

   // Scale operand: zero-extended immediate on the diagonal, zeros elsewhere.
   always_comb begin
      sca_mat = '0;
      for (int i = 0; i < 16; i++) begin
         if (i % 5 == 0) sca_mat[i*EW +: EW] = EW'(addr2);
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!RESET) state <= S_IDLE;
      else        state <= next_state;
   end

   // Next-state selection; handshake states advance only on ack.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE, S_DONE, S_ERR: if (start) next_state = S_FETCH;
         S_FETCH:  if (ack) next_state = S_DECODE;
         S_DECODE: begin
            if (opcode == OPC_STOP)     next_state = S_DONE;
            else if (opcode > OPC_TRA)  next_state = S_ERR;
            else                        next_state = S_RDA;
         end
         S_RDA: begin
            if (ack) begin
               if (opcode == OPC_TRA || opcode == OPC_SCA) next_state = S_DISPA;
               else                                        next_state = S_RDB;
            end
         end
         S_RDB:   if (ack) next_state = S_DISPA;
         S_DISPA: if (ack) next_state = (opcode == OPC_TRA) ? S_WAITR : S_DISPB;
         S_DISPB: if (ack) next_state = S_WAITR;
         S_WAITR: begin
            if (ack) begin
               case (dest)
                  DST_MEM, DST_BOTH: next_state = S_WB_MEM;
                  DST_REG:           next_state = S_WB_REG;
                  default:           next_state = S_WB_NONE;
               endcase
            end
         end
         S_WB_MEM:  if (ack) next_state = (dest == DST_BOTH) ? S_WB_REG : S_FETCH;
         S_WB_REG:  if (ack) next_state = S_FETCH;
         S_WB_NONE: next_state = S_FETCH;
         default:   next_state = S_IDLE;
      endcase
   end

   // Output decode: bus requests, data and status driven purely from state and latched data.
   always_comb begin
      opEN        = 1'b0;
      memEN       = 1'b0;
      memRW       = 1'b0;
      memAddr     = '0;
      toMemBus    = '0;
      regEN       = 1'b0;
      regRW       = 1'b0;
      toRegBus    = '0;
      fuEN        = 1'b0;
      fuSel       = 2'b00;
      add1sub0    = 1'b0;
      toModuleBus = '0;
      done        = 1'b0;
      err         = 1'b0;
      case (state)
         S_FETCH: opEN = !hs_done;
         S_RDA: begin
            if (src1_reg) begin
               regEN = !hs_done;
               regRW = 1'b1;
            end else begin
               memEN   = !hs_done;
               memRW   = 1'b1;
               memAddr = MEM_AW'(addr1);
            end
         end
         S_RDB: begin
            if (src2_reg) begin
               regEN = !hs_done;
               regRW = 1'b1;
            end else begin
               memEN   = !hs_done;
               memRW   = 1'b1;
               memAddr = MEM_AW'(addr2);
            end
         end
         S_DISPA: begin
            fuEN        = !hs_done;
            toModuleBus = mat_a;
         end
         S_DISPB: begin
            fuEN        = !hs_done;
            toModuleBus = mat_b;
         end
         S_WAITR: fuEN = !hs_done;
         S_WB_MEM: begin
            memEN    = !hs_done;
            memAddr  = MEM_AW'(dest_addr);
            toMemBus = res;
         end
         S_WB_REG: begin
            regEN    = !hs_done;
            toRegBus = res;
         end
         S_DONE: done = 1'b1;
         S_ERR:  err  = 1'b1;
         default: ;
      endcase
      busy = !(state inside {S_IDLE, S_DONE, S_ERR});
      // Unit select stays stable for the whole op, decode through writeback.
      if (state inside {S_DECODE, S_RDA, S_RDB, S_DISPA, S_DISPB, S_WAITR,
                        S_WB_MEM, S_WB_REG, S_WB_NONE}) begin
         case (opcode)
            OPC_SUM: begin fuSel = 2'b00; add1sub0 = 1'b1; end
            OPC_SUB: fuSel = 2'b00;
            OPC_MUL, OPC_SCA: fuSel = 2'b01;
            OPC_TRA: fuSel = 2'b10;
            default: fuSel = 2'b00;
         endcase
      end
   end

   // Datapath: op counter, handshake gap flag and data captured on the completing edge.
   always_ff @(posedge clk) begin
      if (!RESET) begin
         opCounter <= '0;
         hs_done   <= 1'b0;
         op_word   <= '0;
         mat_a     <= '0;
         mat_b     <= '0;
         res       <= '0;
      end else begin
         hs_done <= ack;
         if (start_ok)      opCounter <= '0;
         else if (leave_wb) opCounter <= opCounter + OP_AW'(1);
         if (state == S_FETCH && ack) op_word <= fromOpBus;
         if (state == S_RDA && ack) begin
            mat_a <= src1_reg ? fromRegBus : fromMemBus;
            if (opcode == OPC_SCA) mat_b <= sca_mat;
         end
         if (state == S_RDB && ack)   mat_b <= src2_reg ? fromRegBus : fromMemBus;
         if (state == S_WAITR && ack) res   <= fromModBus;
      end
   end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: bus responders with programmable delay plus transaction logs.
// Inputs change on the falling edge; handshakes are logged on the falling edge before the completing rise.
// Expected values are hand-computed constants per directed vector.
module tb_exec_sequencer;

   localparam logic [255:0] JUNK = {8{32'hBAD0_BAD0}};

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [3:0]   opCounter;
   logic         opEN, opFleg;
   logic [31:0]  fromOpBus;
   logic         memEN, memRW, memFleg;
   logic [7:0]   memAddr;
   logic [255:0] fromMemBus, toMemBus;
   logic         regEN, regRW, regFleg;
   logic [255:0] fromRegBus, toRegBus;
   logic [1:0]   fuSel;
   logic         add1sub0, fuEN, fuFleg;
   logic [255:0] toModuleBus, fromModBus;
   logic         busy, done, err;

   // stimulus-side state (owned by the initial block)
   logic [31:0]  op_mem [16];
   logic [255:0] mem_arr [256];
   logic [255:0] reg_store;
   logic [255:0] fu_res;
   int           dly;
   int           clr_gen;
   int           n_chk;
   int           n_fail;

   // log-side state (owned by the falling-edge monitor)
   int           c_op, c_mem, c_reg, c_fu;
   bit           f_op, f_mem, f_reg, f_fu;
   int           clr_seen;
   int           n_fetch, n_mem_rd, n_reg_rd, n_wr, n_fu;
   int           hold_min, hold_max;
   logic [3:0]   fetch_addr [64];
   int           wr_kind [8];
   logic [7:0]   wr_addr [8];
   logic [255:0] wr_dat [8];
   logic [255:0] beat [8];
   logic [1:0]   beat_sel [8];
   logic         beat_as [8];

   exec_sequencer dut (
      .clk(clk), .RESET(rst_n), .start(start),
      .opCounter(opCounter), .opEN(opEN), .opFleg(opFleg), .fromOpBus(fromOpBus),
      .memEN(memEN), .memRW(memRW), .memAddr(memAddr), .memFleg(memFleg),
      .fromMemBus(fromMemBus), .toMemBus(toMemBus),
      .regEN(regEN), .regRW(regRW), .regFleg(regFleg),
      .fromRegBus(fromRegBus), .toRegBus(toRegBus),
      .fuSel(fuSel), .add1sub0(add1sub0), .fuEN(fuEN), .fuFleg(fuFleg),
      .toModuleBus(toModuleBus), .fromModBus(fromModBus),
      .busy(busy), .done(done), .err(err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign opFleg     = opEN  && f_op;
   assign memFleg    = memEN && f_mem;
   assign regFleg    = regEN && f_reg;
   assign fuFleg     = fuEN  && f_fu;
   assign fromOpBus  = opFleg  ? op_mem[opCounter] : 32'hDEAD_BEEF;
   assign fromMemBus = (memFleg && memRW) ? mem_arr[memAddr] : JUNK;
   assign fromRegBus = (regFleg && regRW) ? reg_store : JUNK;
   assign fromModBus = fuFleg ? fu_res : JUNK;

   task automatic note_hold(input int c);
      if (c < hold_min) hold_min = c;
      if (c > hold_max) hold_max = c;
   endtask

   // Responders count EN-high cycles; Fleg rises once the count reaches dly. Completed handshakes are logged.
   always @(negedge clk) begin
      if (clr_gen != clr_seen) begin
         clr_seen = clr_gen;
         n_fetch = 0; n_mem_rd = 0; n_reg_rd = 0; n_wr = 0; n_fu = 0;
         hold_min = 1000; hold_max = 0;
      end
      c_op  = opEN  ? c_op + 1  : 0;  f_op  = (c_op  >= dly);
      c_mem = memEN ? c_mem + 1 : 0;  f_mem = (c_mem >= dly);
      c_reg = regEN ? c_reg + 1 : 0;  f_reg = (c_reg >= dly);
      c_fu  = fuEN  ? c_fu + 1  : 0;  f_fu  = (c_fu  >= dly);
      if (opEN && f_op) begin
         if (n_fetch < 64) fetch_addr[n_fetch] = opCounter;
         n_fetch++;
         note_hold(c_op);
      end
      if (memEN && f_mem) begin
         note_hold(c_mem);
         if (memRW) n_mem_rd++;
         else if (n_wr < 8) begin
            wr_kind[n_wr] = 1; wr_addr[n_wr] = memAddr; wr_dat[n_wr] = toMemBus; n_wr++;
         end
      end
      if (regEN && f_reg) begin
         note_hold(c_reg);
         if (regRW) n_reg_rd++;
         else if (n_wr < 8) begin
            wr_kind[n_wr] = 2; wr_addr[n_wr] = 8'h00; wr_dat[n_wr] = toRegBus; n_wr++;
         end
      end
      if (fuEN && f_fu) begin
         note_hold(c_fu);
         if (n_fu < 8) begin
            beat[n_fu] = toModuleBus; beat_sel[n_fu] = fuSel; beat_as[n_fu] = add1sub0;
         end
         n_fu++;
      end
   end

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mk_op(input logic [3:0] opc, input logic [1:0] dst,
                                         input logic [7:0] da, input logic s1, input logic [7:0] a1,
                                         input logic s2, input logic [7:0] a2);
      return {opc, dst, da, s1, a1, s2, a2};
   endfunction

   task automatic clear_logs();
      clr_gen++;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_end(input string tag, input int bound);
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (done || err) break;
      end
      chk(tag, {255'd0, done || err}, 256'd1);
   endtask

   logic [255:0] diag7;

   initial begin
      n_chk = 0; n_fail = 0; clr_gen = 1; dly = 0;
      rst_n = 1'b0; start = 1'b0;
      reg_store = '0; fu_res = '0;
      for (int i = 0; i < 16; i++)  op_mem[i]  = 32'h0;
      for (int i = 0; i < 256; i++) mem_arr[i] = '0;
      diag7 = 256'h0007_0000_0000_0000_0000_0007_0000_0000_0000_0000_0007_0000_0000_0000_0000_0007;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_opcnt",  {252'd0, opCounter}, 256'd0);
      chk("rst_status", {253'd0, busy, done, err}, 256'd0);
      chk("rst_en",     {252'd0, opEN, memEN, regEN, fuEN}, 256'd0);
      chk("rst_bus",    toModuleBus | toMemBus | toRegBus, 256'd0);
      rst_n = 1'b1;

      // SUM mem/mem -> mem 0x0A, then STOP
      dly = 1;
      op_mem[0] = 32'h1028_0A06;
      mem_arr[8'h05] = {16{16'h0001}};
      mem_arr[8'h06] = {16{16'h0002}};
      fu_res = {16{16'h0003}};
      clear_logs();
      pulse_start();
      wait_end("sum_end", 500);
      chk("sum_status", {253'd0, busy, done, err}, 256'b010);
      chk("sum_nfu",    n_fu, 3);
      chk("sum_beatA",  beat[0], {16{16'h0001}});
      chk("sum_beatB",  beat[1], {16{16'h0002}});
      chk("sum_beatW",  beat[2], 256'd0);
      chk("sum_sel",    {253'd0, beat_sel[0], beat_as[0]}, 256'b001);
      chk("sum_nwr",    n_wr, 1);
      chk("sum_wraddr", {248'd0, wr_addr[0]}, 256'h0A);
      chk("sum_wrdat",  wr_dat[0], {16{16'h0003}});
      chk("sum_fetch",  {248'd0, fetch_addr[0], fetch_addr[1]}, 256'h01);
      chk("sum_opcnt",  {252'd0, opCounter}, 256'd1);

      // SCA reg src1, imm 0x07 -> reg; restart from DONE
      dly = 0;
      op_mem[0] = mk_op(4'd4, 2'b01, 8'h00, 1'b1, 8'h00, 1'b0, 8'h07);
      op_mem[1] = 32'h0;
      reg_store = {16{16'hA5A5}};
      fu_res = {16{16'h1234}};
      clear_logs();
      pulse_start();
      wait_end("sca_end", 500);
      chk("sca_restart", {252'd0, fetch_addr[0]}, 256'd0);
      chk("sca_beatA",   beat[0], {16{16'hA5A5}});
      chk("sca_beatB",   beat[1], diag7);
      chk("sca_sel",     {254'd0, beat_sel[1]}, 256'b01);
      chk("sca_rd",      {n_mem_rd[7:0], n_reg_rd[7:0]}, 256'h0001);
      chk("sca_wr",      {wr_kind[0][7:0], wr_dat[0][247:0]}, {8'd2, fu_res[247:0]});

      // TRA mem 0x20 -> both, dest 0x30
      dly = 2;
      op_mem[0] = mk_op(4'd5, 2'b10, 8'h30, 1'b0, 8'h20, 1'b0, 8'h99);
      mem_arr[8'h20] = {8{32'h0102_0304}};
      fu_res = {8{32'hCAFE_F00D}};
      clear_logs();
      pulse_start();
      wait_end("tra_end", 800);
      chk("tra_nfu",   n_fu, 2);
      chk("tra_beatA", beat[0], {8{32'h0102_0304}});
      chk("tra_beatW", beat[1], 256'd0);
      chk("tra_sel",   {254'd0, beat_sel[0]}, 256'b10);
      chk("tra_nrd",   n_mem_rd, 1);
      chk("tra_nwr",   n_wr, 2);
      chk("tra_order", {wr_kind[0][7:0], wr_kind[1][7:0], wr_addr[0]}, 256'h010230);
      chk("tra_wr0",   wr_dat[0], {8{32'hCAFE_F00D}});
      chk("tra_wr1",   wr_dat[1], {8{32'hCAFE_F00D}});

      // illegal opcode at slot 3
      dly = 0;
      for (int i = 0; i < 3; i++) op_mem[i] = mk_op(4'd1, 2'b11, 8'h00, 1'b0, 8'h01, 1'b0, 8'h02);
      op_mem[3] = 32'h7000_0000;
      clear_logs();
      pulse_start();
      wait_end("err_end", 500);
      repeat (3) @(negedge clk);
      chk("err_status", {253'd0, busy, done, err}, 256'b001);
      chk("err_opcnt",  {252'd0, opCounter}, 256'd3);
      chk("err_nfetch", n_fetch, 4);
      op_mem[0] = 32'h0;
      clear_logs();
      pulse_start();
      wait_end("err_restart_end", 200);
      chk("err_restart", {248'd0, done, err, 2'b00, opCounter}, 256'h80);
      chk("err_restart_fetch", {252'd0, fetch_addr[0]}, 256'd0);

      // SUB mem/reg -> reg with all responders delayed 5 cycles
      dly = 5;
      op_mem[0] = mk_op(4'd2, 2'b01, 8'h00, 1'b0, 8'h11, 1'b1, 8'h00);
      op_mem[1] = 32'h0;
      mem_arr[8'h11] = {16{16'h0777}};
      reg_store = {16{16'h0100}};
      fu_res = {16{16'h0677}};
      clear_logs();
      pulse_start();
      wait_end("dly_end", 2000);
      chk("dly_beatA", beat[0], {16{16'h0777}});
      chk("dly_beatB", beat[1], {16{16'h0100}});
      chk("dly_sel",   {253'd0, beat_sel[0], beat_as[0]}, 256'b000);
      chk("dly_wr",    wr_dat[0], {16{16'h0677}});
      chk("dly_hold",  {hold_min[15:0], hold_max[15:0]}, {16'd5, 16'd5});

      // reset while RDA of slot 1 holds memEN
      op_mem[0] = mk_op(4'd1, 2'b11, 8'h00, 1'b0, 8'h01, 1'b0, 8'h02);
      op_mem[1] = op_mem[0];
      clear_logs();
      pulse_start();
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (n_fetch >= 2 && memEN) break;
      end
      chk("mid_rda",   {255'd0, memEN}, 256'd1);
      chk("mid_opcnt", {252'd0, opCounter}, 256'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst",   {252'd0, memEN, busy, fuEN, opEN}, 256'd0);
      chk("mid_rst_opcnt", {252'd0, opCounter}, 256'd0);
      rst_n = 1'b1;
      dly = 0;
      op_mem[0] = 32'h0;
      clear_logs();
      pulse_start();
      wait_end("mid_restart_end", 200);
      chk("mid_restart", {252'd0, fetch_addr[0]}, 256'd0);

      // 16 non-STOP ops: counter wraps and execution continues
      for (int i = 0; i < 16; i++) op_mem[i] = mk_op(4'd1, 2'b11, 8'h00, 1'b0, 8'h01, 1'b0, 8'h02);
      clear_logs();
      pulse_start();
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (n_fetch >= 18) break;
      end
      chk("wrap_reached", {255'd0, n_fetch >= 18}, 256'd1);
      chk("wrap_addrs", {240'd0, fetch_addr[15], fetch_addr[16], fetch_addr[17], 4'h0}, 256'hF010);
      chk("wrap_busy", {254'd0, busy, err}, 256'b10);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
